// File: rtl/cart_loader.sv
// Cartridge download path: buffers iosys ROM bytes, writes them to SDRAM channel 0
// through the toggle handshake, then derives image size masks for the read path.
module cart_loader #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              req0,
  input  logic              ack0,
  output logic [ADDR_W-1:0] addr0,
  output logic [7:0]        din0,
  output logic              sys_reset,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [ADDR_W-1:0] cart_mask512,
  output logic              cart_sz512,
  output logic [ADDR_W:0]   load_bytes,
  output logic              overflow,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state;
  logic                  rom_loading_q;
  logic [ADDR_W+7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic                  rom_rise;
  logic                  rom_fall;
  logic                  chan_idle;
  logic                  push_try;
  logic                  push;
  logic                  pop;
  logic                  sz512;
  logic [ADDR_W:0]       bytes_less_hdr;

  // Ones from bit 0 up to the MSB of n-1, i.e. the smallest power-of-two window holding n bytes.
  function automatic logic [ADDR_W-1:0] size_mask(input logic [ADDR_W:0] n);
    logic [ADDR_W:0]   v;
    logic [ADDR_W-1:0] m;
    v = n - 1'b1;
    m = '0;
    m[ADDR_W-1] = v[ADDR_W-1];
    for (int i = ADDR_W - 2; i >= 0; i--) m[i] = v[i] | m[i+1];
    return (n <= (ADDR_W + 1)'(1)) ? '0 : m;
  endfunction

  // NOTE: edges are taken against a registered copy so each transition is seen exactly once.
  assign rom_rise  = rom_loading & ~rom_loading_q;
  assign rom_fall  = ~rom_loading & rom_loading_q;
  assign chan_idle = (req0 == ack0);

  assign push_try = (state == LOAD) && rom_do_valid && !rom_rise;
  assign push     = push_try && (count != FIFO_FULL) && !load_bytes[ADDR_W];
  assign pop      = ((state == LOAD) || (state == DRAIN)) && chan_idle &&
                    (count != '0) && !rom_rise;

  assign sz512          = (load_bytes[9:0] == 10'd512);
  assign bytes_less_hdr = load_bytes - (ADDR_W + 1)'(512);
  assign busy           = (state == LOAD) || (state == DRAIN);

  // NOTE: the FIFO storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {load_bytes[ADDR_W-1:0], rom_do};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rom_loading_q <= 1'b0;
      req0          <= 1'b0;
      addr0         <= '0;
      din0          <= '0;
      sys_reset     <= 1'b1;
      cart_mask     <= '0;
      cart_mask512  <= '0;
      cart_sz512    <= 1'b0;
      load_bytes    <= '0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      rom_loading_q <= rom_loading;
      if (rom_rise) begin
        // A write already in flight keeps req0 as is; the flushed FIFO blocks new issues.
        state      <= LOAD;
        sys_reset  <= 1'b1;
        load_bytes <= '0;
        overflow   <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          load_bytes <= load_bytes + 1'b1;
        end
        if (push_try && !push) overflow <= 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          addr0  <= fifo_mem[rd_ptr][ADDR_W+7:8];
          din0   <= fifo_mem[rd_ptr][7:0];
          req0   <= ~req0;
        end
        count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

        case (state)
          LOAD:  if (rom_fall) state <= DRAIN;
          DRAIN: begin
            if ((count == '0) && chan_idle) begin
              state        <= DONE;
              cart_sz512   <= sz512;
              cart_mask    <= size_mask(load_bytes);
              cart_mask512 <= sz512 ? size_mask(bytes_less_hdr) : size_mask(load_bytes);
            end
          end
          DONE:    sys_reset <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
